// File: rtl/lifo_ext.sv
// lifo_ext: parametrised FWFT stack with bypass, threshold and sticky error flags.
// Optional high-water mark tracking enabled by defining LIFO_HWM_EN.
module lifo_ext #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int AF_THR  = DEPTH - 1,
  parameter int AE_THR  = 1,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              w_req,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_req,
  output logic [DATA_W-1:0] r_data,
  output logic [DEPTH_W-1:0] cnt,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              ovf,
  output logic              udf,
  input  logic              err_clr
`ifdef LIFO_HWM_EN
  ,
  input  logic              hwm_clr,
  output logic [DEPTH_W-1:0] hwm
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL_C = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] AF_C   = DEPTH_W'(AF_THR);
  localparam logic [DEPTH_W-1:0] AE_C   = DEPTH_W'(AE_THR);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] cnt_nxt;
  logic [AW-1:0]      top_idx;
  logic [AW-1:0]      wr_idx;
  logic               push, pop, both;
  logic               do_push, do_pop, do_repl;
  logic               bypass;
  logic               wr_en;
  logic               ovf_set, udf_set;

  assign push    = w_req & ~r_req;
  assign pop     = r_req & ~w_req;
  assign both    = w_req & r_req;

  assign empty        = (cnt == '0);
  assign full         = (cnt == FULL_C);
  assign almost_empty = (cnt <= AE_C);
  assign almost_full  = (cnt >= AF_C);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign do_repl = both & ~empty;
  assign bypass  = both & empty;
  assign ovf_set = push & full;
  assign udf_set = pop & empty;

  assign top_idx = AW'(cnt - 1'b1);
  assign wr_en   = do_push | do_repl;
  assign wr_idx  = do_push ? AW'(cnt) : top_idx;

  always_comb begin
    r_data = '0;
    unique case (1'b1)
      bypass: r_data = w_data;
      !empty: r_data = mem[top_idx];
      default: ;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      do_push: cnt_nxt = cnt + 1'b1;
      do_pop:  cnt_nxt = cnt - 1'b1;
      default: ;
    endcase
  end

  // Storage deliberately has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= w_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_set | (ovf & ~err_clr);
      udf <= udf_set | (udf & ~err_clr);
    end
  end

`ifdef LIFO_HWM_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hwm <= '0;
    end else if (hwm_clr) begin
      hwm <= cnt;
    end else if (cnt_nxt > hwm) begin
      hwm <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_ext.sv
// tb_lifo_ext: directed and random stimulus against a queue-based stack model.
// Default build (LIFO_HWM_EN undefined), DEPTH=5, DATA_W=8, AF_THR=4, AE_THR=1.
module tb_lifo_ext;

  localparam int DEPTH  = 5;
  localparam int DW     = 8;
  localparam int AF     = 4;
  localparam int AE     = 1;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          w_req = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_req = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] r_data;
  logic [CW-1:0] cnt;
  logic          empty, full, almost_empty, almost_full, ovf, udf;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] stk[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  lifo_ext #(
    .DEPTH(DEPTH), .DATA_W(DW), .AF_THR(AF), .AE_THR(AE)
  ) dut (
    .clk(clk), .nrst(nrst),
    .w_req(w_req), .w_data(w_data),
    .r_req(r_req), .r_data(r_data),
    .cnt(cnt), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] top_of(input logic [DW-1:0] d,
                                           input logic w, input logic r);
    if (w && r && stk.size() == 0) return d;
    if (stk.size() == 0) return '0;
    return stk[stk.size()-1];
  endfunction

  task automatic chk_state(input string tag);
    int n;
    n = stk.size();
    chk({tag, ".cnt"}, 32'(cnt), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
    chk({tag, ".rdata"}, 32'(r_data), 32'(top_of(w_data, w_req, r_req)));
  endtask

  // One clock of stimulus: check the same-cycle view, then the post-edge state.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [DW-1:0] d, input logic c);
    int n;
    logic no, nu;
    @(negedge clk);
    w_req = w; r_req = r; w_data = d; err_clr = c;
    #1;
    chk({tag, ".now"}, 32'(r_data), 32'(top_of(d, w, r)));
    @(posedge clk);
    n = stk.size();
    no = 1'b0; nu = 1'b0;
    if (w && !r) begin
      if (n < DEPTH) stk.push_back(d);
      else no = 1'b1;
    end else if (r && !w) begin
      if (n > 0) void'(stk.pop_back());
      else nu = 1'b1;
    end else if (w && r && n > 0) begin
      stk[n-1] = d;
    end
    m_ovf = no | (m_ovf & ~c);
    m_udf = nu | (m_udf & ~c);
    #1;
    w_req = 1'b0; r_req = 1'b0; err_clr = 1'b0;
    #1;
    chk_state(tag);
  endtask

  initial begin
    #3;
    chk_state("reset");
    @(negedge clk);
    nrst = 1'b1;

    step("p11", 1, 0, 8'h11, 0);
    step("p22", 1, 0, 8'h22, 0);
    step("p33", 1, 0, 8'h33, 0);
    for (int i = 0; i < 3; i++) step("pop3", 0, 1, 8'h00, 0);

    for (int i = 0; i < 6; i++) step("pushA", 1, 0, 8'hA0 + 8'(i), 0);
    step("eclr", 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step("drain", 0, 1, 8'h00, 0);

    step("udf", 0, 1, 8'h00, 0);
    step("udf_clr", 0, 1, 8'h00, 1);
    step("udf_clr2", 0, 0, 8'h00, 1);

    step("r1", 1, 0, 8'h41, 0);
    step("r2", 1, 0, 8'h42, 0);
    step("repl", 1, 1, 8'h77, 0);
    for (int i = 0; i < 3; i++) step("fill", 1, 0, 8'h50 + 8'(i), 0);
    step("repl_full", 1, 1, 8'h88, 0);
    for (int i = 0; i < 5; i++) step("drain2", 0, 1, 8'h00, 0);

    step("bypass", 1, 1, 8'h5A, 0);

    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      step("rand", k < 4 || k == 8, (k >= 4 && k < 7) || k == 8,
           8'($urandom), $urandom_range(0, 7) == 0);
    end

    while (stk.size() > 4) step("pre_rst", 0, 1, 8'h00, 0);
    while (stk.size() < 4) step("pre_rst", 1, 0, 8'($urandom), 0);
    step("pre_rst_udf", 0, 0, 8'h00, 0);
    @(negedge clk);
    #2;
    nrst = 1'b0;
    stk.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    chk_state("async_rst");
    @(negedge clk);
    nrst = 1'b1;
    step("post_rst", 1, 0, 8'h99, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_ext.md
# lifo_ext

Parametrised single-clock LIFO (stack) for control-path buffering: one push port, one pop port, first-word-fall-through top-of-stack output. It extends the basic stack with any-integer depth, a correctly sized element counter, a same-cycle bypass when empty, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags. It sits between a producer and a consumer that both use single-cycle request strobes with no backpressure handshake.

## Interface
- DEPTH, 8: max element count; any integer >= 2 (power of 2 not required)
- DATA_W, 32: data width
- AF_THR, DEPTH-1: almost_full asserted when cnt >= AF_THR
- AE_THR, 1: almost_empty asserted when cnt <= AE_THR
- DEPTH_W, $clog2(DEPTH+1): counter width; derived, do not override
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- w_req  in  1  push strobe
- w_data  in  DATA_W  push data
- r_req  in  1  pop strobe
- r_data  out  DATA_W  top of stack (FWFT)
- cnt  out  DEPTH_W  current element count
- empty, full  out  1 each  cnt==0 / cnt==DEPTH
- almost_empty, almost_full  out  1 each  threshold flags
- ovf, udf  out  1 each  sticky overflow / underflow
- err_clr  in  1  clears ovf and udf
- hwm  out  DEPTH_W  high-water mark (only with LIFO_HWM_EN)
- hwm_clr  in  1  clears hwm (only with LIFO_HWM_EN)

## Operation
- Reset (nrst low, async): cnt=0, ovf=0, udf=0, hwm=0; storage not reset (RAM-inferable). Outputs after reset: r_data=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THR==0).
- r_data = storage[cnt-1] when cnt>0; 0 when empty, except bypass case below.
- {w_req,r_req}=10, not full: storage[cnt]<=w_data, cnt+1.
- 10, full: write dropped, cnt unchanged, ovf<=1.
- 01, not empty: cnt-1; storage unchanged.
- 01, empty: no change, udf<=1.
- 11, not empty: storage[cnt-1]<=w_data (top replaced), cnt unchanged; consumer receives old top this cycle. Valid when full; no ovf.
- 11, empty: bypass. r_data = w_data combinationally this cycle, nothing stored, cnt stays 0, no flags.
- 00: no change.
- err_clr: ovf/udf <= 0; a new error in the same cycle wins (flag stays/gets set).
- empty, full, almost_* are combinational decodes of registered cnt.
- Counter never wraps: saturates by rule above at 0 and DEPTH.

## Timing
- Push visible on r_data/cnt one cycle after the strobe edge.
- Pop: r_data shows the popped word during the strobe cycle; next word on the following cycle.
- ovf/udf set on the edge that samples the offending request; visible next cycle.
- Only combinational input-to-output path: w_data -> r_data (bypass, gated by empty & w_req & r_req).
- nrst assertion mid-operation clears state immediately, regardless of clk; deassertion is synchronised externally.

## Configuration
- LIFO_HWM_EN defined: hwm register tracks max cnt since reset or last hwm_clr; updates to new cnt on the same edge cnt changes; hwm_clr loads current cnt (not 0); hwm and hwm_clr ports present.
- Not defined: no hwm logic, hwm and hwm_clr ports absent; all other behaviour identical.

## Test plan
DEPTH=5, DATA_W=8, AF_THR=4, AE_THR=1.
- Reset, push 0x11,0x22,0x33 -> cnt=3, r_data=0x33; pop three -> r_data 0x33,0x22,0x11, then empty=1, r_data=0.
- Push 6 words 0xA0..0xA5 -> cnt=5, full=1, top=0xA4, ovf=1 after 6th; err_clr -> ovf=0.
- Pop on empty -> udf=1, cnt=0; err_clr and pop together on empty -> udf stays 1.
- cnt=2, w_req=r_req=1 with 0x77 -> r_data old top that cycle, then 0x77, cnt=2; same when full -> cnt=5, ovf=0.
- Empty, w_req=r_req=1 with 0x5A -> r_data=0x5A same cycle, next cycle cnt=0, r_data=0.
- Push to cnt=4 (almost_full=1), pulse nrst low between edges -> cnt=0, flags cleared immediately; with LIFO_HWM_EN, hwm=4 before reset, 0 after.
